// File: rtl/control_sequencer_if.sv
// Control bus between the instruction sequencer and the datapath.
// The sequencer (master) samples ir/mem_ready/cont and drives every strobe;
// the datapath side (slave) sees the same signals with directions reversed.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        cont;

    logic        PCout;
    logic        Zlowout;
    logic        Zhighout;
    logic        MDRout;

    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        HIin;
    logic        LOin;

    logic        IncPC;
    logic        Read;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic [4:0]  alu_op;
    logic        run;

    modport master (
        input  ir, mem_ready, cont,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, run
    );

    modport slave (
        output ir, mem_ready, cont,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Instruction fetch/execute sequencer for a simple bus-based datapath.
//
// state | meaning
// T0    | PC onto bus, load MAR, compute PC+1 into Z
// T1    | PC <- Z (first cycle only), read memory into MDR until mem_ready
// T2    | MDR onto bus, load IR; opcode latched on exit
// T3-T6 | execute steps, selected by latched opcode class
// HALT  | idle with run=0 until cont
//
// Outputs are registered: each edge computes the next state and loads the
// strobes belonging to that state, so no input reaches an output without a
// flop in between.  rst_hold marks the cycle(s) spent in reset: the state is
// already T0 but nothing is driven, and the first edge with rst low enters a
// real T0 cycle instead of advancing past it.
module control_sequencer (
    input  logic clk,
    input  logic rst,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef struct packed {
        logic       pc_out;
        logic       zlow_out;
        logic       zhigh_out;
        logic       mdr_out;
        logic       mar_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       inc_pc;
        logic       read;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic [4:0] alu_op;
        logic       run;
    } strobes_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] op_q;
    logic [4:0] op_nxt;
    logic       rst_hold;
    strobes_t   outs;

    logic unused_ir;
    assign unused_ir = ^bus.ir[26:0];

    function automatic logic is_alu3(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Strobe pattern for a state; t1_first marks the cycle T1 is entered.
    function automatic strobes_t decode(input state_t st, input logic [4:0] op,
                                        input logic t1_first);
        strobes_t s;
        s = '0;
        s.run = (st != HALT);
        case (st)
            T0: begin
                s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1;
            end
            T1: begin
                s.zlow_out = t1_first; s.pc_in = t1_first;
                s.read = 1'b1; s.mdr_in = 1'b1;
            end
            T2: begin
                s.mdr_out = 1'b1; s.ir_in = 1'b1;
            end
            T3: begin
                if (is_alu3(op)) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1;
                end else if (is_unary(op)) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; s.alu_op = op;
                end else if (is_muldiv(op)) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1;
                end
            end
            T4: begin
                if (is_alu3(op)) begin
                    s.grc = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; s.alu_op = op;
                end else if (is_unary(op)) begin
                    s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (is_muldiv(op)) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; s.alu_op = op;
                end
            end
            T5: begin
                if (is_alu3(op)) begin
                    s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (is_muldiv(op)) begin
                    s.zlow_out = 1'b1; s.lo_in = 1'b1;
                end
            end
            T6: begin
                s.zhigh_out = 1'b1; s.hi_in = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

    // Next state and opcode; the opcode is taken from ir only when leaving T2.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        case (state)
            T0: state_nxt = T1;
            T1: if (bus.mem_ready) state_nxt = T2;
            T2: begin
                op_nxt = bus.ir[31:27];
                if (op_nxt == OP_HALT)
                    state_nxt = HALT;
                else if (is_alu3(op_nxt) || is_unary(op_nxt) || is_muldiv(op_nxt))
                    state_nxt = T3;
                else
                    state_nxt = T0;
            end
            T3: state_nxt = T4;
            T4: state_nxt = is_unary(op_q) ? T0 : T5;
            T5: state_nxt = is_muldiv(op_q) ? T6 : T0;
            T6: state_nxt = T0;
            HALT: if (bus.cont) state_nxt = T0;
            default: state_nxt = T0;
        endcase
    end

    // State, latched opcode and registered strobes; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= T0;
            op_q     <= 5'b00000;
            rst_hold <= 1'b1;
            outs     <= '0;
        end else if (rst_hold) begin
            rst_hold <= 1'b0;
            state    <= T0;
            outs     <= decode(T0, op_q, 1'b0);
        end else begin
            state    <= state_nxt;
            op_q     <= op_nxt;
            outs     <= decode(state_nxt, op_nxt, state == T0);
        end
    end

    assign bus.PCout    = outs.pc_out;
    assign bus.Zlowout  = outs.zlow_out;
    assign bus.Zhighout = outs.zhigh_out;
    assign bus.MDRout   = outs.mdr_out;
    assign bus.MARin    = outs.mar_in;
    assign bus.PCin     = outs.pc_in;
    assign bus.MDRin    = outs.mdr_in;
    assign bus.IRin     = outs.ir_in;
    assign bus.Yin      = outs.y_in;
    assign bus.Zin      = outs.z_in;
    assign bus.HIin     = outs.hi_in;
    assign bus.LOin     = outs.lo_in;
    assign bus.IncPC    = outs.inc_pc;
    assign bus.Read     = outs.read;
    assign bus.Gra      = outs.gra;
    assign bus.Grb      = outs.grb;
    assign bus.Grc      = outs.grc;
    assign bus.Rin      = outs.r_in;
    assign bus.Rout     = outs.r_out;
    assign bus.alu_op   = outs.alu_op;
    assign bus.run      = outs.run;

endmodule
